// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package rf_sched_pkg;

    localparam int RF_ADDR_W  = 5;
    localparam int RF_DATA_W  = 32;
    localparam int RF_ENTRIES = 32;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LD   = 2'd2
    } grant_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: per-register pending bits, outstanding count,
// sticky protocol error and read-hazard lookup for the issue stage.
module rf_scoreboard
    import rf_sched_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [RF_ADDR_W-1:0] issue_addr,
    output logic                 issue_ready,
    input  logic                 ld_fire,
    input  logic [RF_ADDR_W-1:0] ld_addr,
    input  logic                 alu_fire,
    input  logic [RF_ADDR_W-1:0] alu_addr,
    input  logic [RF_ADDR_W-1:0] rd_addr_0,
    input  logic [RF_ADDR_W-1:0] rd_addr_1,
    input  logic                 wr_enable,
    input  logic [RF_ADDR_W-1:0] wr_addr,
    output logic                 rd_hazard,
    output logic [5:0]           pending_count,
    output logic                 sb_error
);

    localparam logic [5:0] MAX_CNT = 6'(MAX_PENDING);

    logic [RF_ENTRIES-1:0] pending;
    logic [RF_ENTRIES-1:0] pending_next;
    logic                  issue_fire;
    logic                  ld_retire;
    logic                  bad_write;

    assign issue_ready = (pending_count != MAX_CNT) && !pending[issue_addr];
    assign issue_fire  = issue_valid && issue_ready;
    assign ld_retire   = ld_fire && pending[ld_addr];
    assign bad_write   = (alu_fire && pending[alu_addr]) || (ld_fire && !pending[ld_addr]);

    // Clear before set so a same-edge re-issue leaves the register pending.
    always_comb begin
        pending_next = pending;
        if (ld_fire)
            pending_next[ld_addr] = 1'b0;
        if (issue_fire)
            pending_next[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= '0;
            pending_count <= '0;
            sb_error      <= 1'b0;
        end else begin
            pending <= pending_next;
            case ({issue_fire, ld_retire})
                2'b10:   pending_count <= pending_count + 6'd1;
                2'b01:   pending_count <= pending_count - 6'd1;
                default: pending_count <= pending_count;
            endcase
            sb_error <= sb_error | bad_write;
        end
    end

    // A write sitting on the registered port is not yet readable from the file.
    assign rd_hazard = pending[rd_addr_0] || pending[rd_addr_1] ||
                       (wr_enable && ((wr_addr == rd_addr_0) || (wr_addr == rd_addr_1)));

endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback arbiter and registered write port for the 2R/1W register file.
// Optional macro RF_WB_STARVE_EN enables load anti-starvation pre-emption.
module rf_wb_scheduler
    import rf_sched_pkg::*;
#(
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 rf_clock,
    input  logic                 rf_reset,
    input  logic                 alu_wb_valid,
    output logic                 alu_wb_ready,
    input  logic [RF_ADDR_W-1:0] alu_wb_addr,
    input  logic [RF_DATA_W-1:0] alu_wb_data,
    input  logic                 ld_wb_valid,
    output logic                 ld_wb_ready,
    input  logic [RF_ADDR_W-1:0] ld_wb_addr,
    input  logic [RF_DATA_W-1:0] ld_wb_data,
    input  logic                 ld_issue_valid,
    input  logic [RF_ADDR_W-1:0] ld_issue_addr,
    output logic                 ld_issue_ready,
    input  logic [RF_ADDR_W-1:0] rd_addr_0,
    input  logic [RF_ADDR_W-1:0] rd_addr_1,
    output logic                 rd_hazard,
    output logic                 rf_wr_enable,
    output logic [RF_ADDR_W-1:0] rf_wr_addr,
    output logic [RF_DATA_W-1:0] rf_wr_data,
    output logic [5:0]           pending_count,
    output logic                 sb_error
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    wb_req_t alu_req;
    wb_req_t ld_req;
    grant_e  grant;
    logic    ld_preempt;
    logic    alu_fire;
    logic    ld_fire;

    logic                 wr_en_p1;
    logic [RF_ADDR_W-1:0] wr_addr_p1;
    logic [RF_DATA_W-1:0] wr_data_p1;

    assign alu_req = '{valid: alu_wb_valid, addr: alu_wb_addr, data: alu_wb_data};
    assign ld_req  = '{valid: ld_wb_valid,  addr: ld_wb_addr,  data: ld_wb_data};

`ifdef RF_WB_STARVE_EN
    logic [3:0] starve_cnt;

    always_ff @(posedge rf_clock) begin
        if (rf_reset)
            starve_cnt <= 4'd0;
        else if (ld_wb_valid && !ld_wb_ready)
            starve_cnt <= sat_inc4(starve_cnt);
        else
            starve_cnt <= 4'd0;
    end

    assign ld_preempt = (starve_cnt >= STARVE_LIM);
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = ^STARVE_LIM;
    assign ld_preempt        = 1'b0;
`endif

    always_comb begin
        grant = GRANT_NONE;
        if (alu_req.valid && !(ld_req.valid && ld_preempt))
            grant = GRANT_ALU;
        else if (ld_req.valid)
            grant = GRANT_LD;
    end

    // The ALU side holds ready while idle so exactly one ready is ever high.
    assign ld_wb_ready  = (grant == GRANT_LD);
    assign alu_wb_ready = !ld_wb_ready;
    assign alu_fire     = alu_req.valid && alu_wb_ready;
    assign ld_fire      = ld_req.valid && ld_wb_ready;

    // ---- stage p1: registered write port ----
    always_ff @(posedge rf_clock) begin
        if (rf_reset) begin
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_en_p1 <= alu_fire || ld_fire;
            if (ld_fire) begin
                wr_addr_p1 <= ld_req.addr;
                wr_data_p1 <= ld_req.data;
            end else if (alu_fire) begin
                wr_addr_p1 <= alu_req.addr;
                wr_data_p1 <= alu_req.data;
            end
        end
    end

    assign rf_wr_enable = wr_en_p1;
    assign rf_wr_addr   = wr_addr_p1;
    assign rf_wr_data   = wr_data_p1;

    rf_scoreboard #(
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk           (rf_clock),
        .rst           (rf_reset),
        .issue_valid   (ld_issue_valid),
        .issue_addr    (ld_issue_addr),
        .issue_ready   (ld_issue_ready),
        .ld_fire       (ld_fire),
        .ld_addr       (ld_req.addr),
        .alu_fire      (alu_fire),
        .alu_addr      (alu_req.addr),
        .rd_addr_0     (rd_addr_0),
        .rd_addr_1     (rd_addr_1),
        .wr_enable     (wr_en_p1),
        .wr_addr       (wr_addr_p1),
        .rd_hazard     (rd_hazard),
        .pending_count (pending_count),
        .sb_error      (sb_error)
    );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios plus randomized
// traffic compared against a behavioural model of the writeback rules.
module tb_rf_wb_scheduler;

    localparam int MAX_PENDING  = 4;
    localparam int STARVE_LIMIT = 3;
`ifdef RF_WB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        rf_clock = 1'b0;
    logic        rf_reset;
    logic        alu_wb_valid, alu_wb_ready;
    logic [4:0]  alu_wb_addr;
    logic [31:0] alu_wb_data;
    logic        ld_wb_valid, ld_wb_ready;
    logic [4:0]  ld_wb_addr;
    logic [31:0] ld_wb_data;
    logic        ld_issue_valid, ld_issue_ready;
    logic [4:0]  ld_issue_addr;
    logic [4:0]  rd_addr_0, rd_addr_1;
    logic        rd_hazard;
    logic        rf_wr_enable;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [5:0]  pending_count;
    logic        sb_error;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_scheduler #(
        .MAX_PENDING  (MAX_PENDING),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .rf_clock       (rf_clock),
        .rf_reset       (rf_reset),
        .alu_wb_valid   (alu_wb_valid),
        .alu_wb_ready   (alu_wb_ready),
        .alu_wb_addr    (alu_wb_addr),
        .alu_wb_data    (alu_wb_data),
        .ld_wb_valid    (ld_wb_valid),
        .ld_wb_ready    (ld_wb_ready),
        .ld_wb_addr     (ld_wb_addr),
        .ld_wb_data     (ld_wb_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_addr  (ld_issue_addr),
        .ld_issue_ready (ld_issue_ready),
        .rd_addr_0      (rd_addr_0),
        .rd_addr_1      (rd_addr_1),
        .rd_hazard      (rd_hazard),
        .rf_wr_enable   (rf_wr_enable),
        .rf_wr_addr     (rf_wr_addr),
        .rf_wr_data     (rf_wr_data),
        .pending_count  (pending_count),
        .sb_error       (sb_error)
    );

    always #5 rf_clock = ~rf_clock;

    // Reference model state
    bit [31:0] m_pend;
    int        m_cnt;
    bit        m_err;
    int        m_starve;
    bit        m_we;
    bit [4:0]  m_wa;
    bit [31:0] m_wd;

    function automatic bit m_ld_grant();
        return ld_wb_valid && (!alu_wb_valid || (STARVE_ON && m_starve >= STARVE_LIMIT));
    endfunction

    function automatic bit m_iss_rdy();
        return (m_cnt != MAX_PENDING) && !m_pend[ld_issue_addr];
    endfunction

    function automatic bit m_haz();
        return m_pend[rd_addr_0] || m_pend[rd_addr_1] ||
               (m_we && (m_wa == rd_addr_0 || m_wa == rd_addr_1));
    endfunction

    function automatic logic [48:0] exp_vec();
        return {!m_ld_grant(), m_ld_grant(), m_iss_rdy(), m_haz(), m_we,
                m_we ? m_wa : 5'd0, m_we ? m_wd : 32'd0, 6'(m_cnt), m_err};
    endfunction

    function automatic logic [48:0] act_vec();
        return {alu_wb_ready, ld_wb_ready, ld_issue_ready, rd_hazard, rf_wr_enable,
                rf_wr_enable ? rf_wr_addr : 5'd0, rf_wr_enable ? rf_wr_data : 32'd0,
                pending_count, sb_error};
    endfunction

    task automatic m_step();
        bit lg, af, lf, isf;
        if (rf_reset) begin
            m_pend = '0; m_cnt = 0; m_err = 0; m_starve = 0;
            m_we = 0; m_wa = '0; m_wd = '0;
            return;
        end
        lg  = m_ld_grant();
        af  = alu_wb_valid && !lg;
        lf  = ld_wb_valid && lg;
        isf = ld_issue_valid && m_iss_rdy();
        if (af && m_pend[alu_wb_addr]) m_err = 1;
        if (lf && !m_pend[ld_wb_addr]) m_err = 1;
        if (isf) m_cnt++;
        if (lf && m_pend[ld_wb_addr]) m_cnt--;
        if (lf) m_pend[ld_wb_addr] = 1'b0;
        if (isf) m_pend[ld_issue_addr] = 1'b1;
        m_starve = (ld_wb_valid && !lg) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
        m_we = af || lf;
        if (lf) begin m_wa = ld_wb_addr; m_wd = ld_wb_data; end
        else if (af) begin m_wa = alu_wb_addr; m_wd = alu_wb_data; end
    endtask

    task automatic tick();
        @(posedge rf_clock);
        m_step();
        @(negedge rf_clock);
    endtask

    task automatic idle_inputs();
        alu_wb_valid = 0; alu_wb_addr = '0; alu_wb_data = '0;
        ld_wb_valid = 0; ld_wb_addr = '0; ld_wb_data = '0;
        ld_issue_valid = 0; ld_issue_addr = '0;
        rd_addr_0 = '0; rd_addr_1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rf_reset = 1; tick(); rf_reset = 0;
    endtask

    task automatic test_reset();
        do_reset(); do_reset();
        #1;
        n_tests++;
        if ({rf_wr_enable, rf_wr_addr, rf_wr_data} !== 38'd0) begin
            n_fail++; $display("FAIL reset_wr_port: got %0b/%0d/%h want 0/0/0", rf_wr_enable, rf_wr_addr, rf_wr_data);
        end
        n_tests++;
        if (pending_count !== 6'd0 || sb_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_sb: got cnt=%0d err=%0b want 0/0", pending_count, sb_error);
        end
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_alu_write();
        alu_wb_valid = 1; alu_wb_addr = 5'd5; alu_wb_data = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (alu_wb_ready !== 1'b1) begin
            n_fail++; $display("FAIL alu_ready: got %0b want 1", alu_wb_ready);
        end
        tick();
        alu_wb_valid = 0;
        #1;
        n_tests++;
        if ({rf_wr_enable, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL alu_write: got %0b/%0d/%h want 1/5/deadbeef", rf_wr_enable, rf_wr_addr, rf_wr_data);
        end
        tick(); #1;
        n_tests++;
        if (rf_wr_enable !== 1'b0) begin
            n_fail++; $display("FAIL alu_write_idle: got %0b want 0", rf_wr_enable);
        end
    endtask

    task automatic test_load_hazard();
        ld_issue_valid = 1; ld_issue_addr = 5'd7;
        #1;
        n_tests++;
        if (ld_issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL issue_r7_ready: got %0b want 1", ld_issue_ready);
        end
        tick();
        ld_issue_valid = 0; rd_addr_0 = 5'd7; rd_addr_1 = 5'd0;
        #1;
        n_tests++;
        if (rd_hazard !== 1'b1 || pending_count !== 6'd1) begin
            n_fail++; $display("FAIL hazard_pending: got haz=%0b cnt=%0d want 1/1", rd_hazard, pending_count);
        end
        ld_wb_valid = 1; ld_wb_addr = 5'd7; ld_wb_data = 32'h0000_1234;
        tick();
        ld_wb_valid = 0;
        #1;
        n_tests++;
        if (rd_hazard !== 1'b1 || pending_count !== 6'd0 || rf_wr_enable !== 1'b1 || rf_wr_addr !== 5'd7) begin
            n_fail++; $display("FAIL hazard_inflight: got haz=%0b cnt=%0d we=%0b wa=%0d want 1/0/1/7",
                               rd_hazard, pending_count, rf_wr_enable, rf_wr_addr);
        end
        tick(); #1;
        n_tests++;
        if (rd_hazard !== 1'b0) begin
            n_fail++; $display("FAIL hazard_cleared: got %0b want 0", rd_hazard);
        end
    endtask

    task automatic test_starve();
        bit exp_ld;
        do_reset();
        alu_wb_valid = 1; alu_wb_addr = 5'd8;  alu_wb_data = 32'h1;
        ld_wb_valid  = 1; ld_wb_addr  = 5'd20; ld_wb_data  = 32'h100;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_ld = STARVE_ON && (i % 4 == 3);
            n_tests++;
            if (ld_wb_ready !== exp_ld || alu_wb_ready !== !exp_ld) begin
                n_fail++; $display("FAIL starve_cycle%0d: got ld=%0b alu=%0b want ld=%0b", i, ld_wb_ready, alu_wb_ready, exp_ld);
            end
            tick();
            if (exp_ld) ld_wb_data = ld_wb_data + 1;
            else begin alu_wb_addr = alu_wb_addr + 5'd1; alu_wb_data = alu_wb_data + 1; end
        end
        idle_inputs();
    endtask

    task automatic test_max_pending();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            ld_issue_valid = 1; ld_issue_addr = 5'(i);
            #1;
            n_tests++;
            if (ld_issue_ready !== 1'b1) begin
                n_fail++; $display("FAIL issue_r%0d_ready: got %0b want 1", i, ld_issue_ready);
            end
            tick();
        end
        ld_issue_addr = 5'd9;
        #1;
        n_tests++;
        if (ld_issue_ready !== 1'b0 || pending_count !== 6'd4) begin
            n_fail++; $display("FAIL issue_full: got rdy=%0b cnt=%0d want 0/4", ld_issue_ready, pending_count);
        end
        ld_issue_valid = 0; ld_wb_valid = 1; ld_wb_addr = 5'd4; ld_wb_data = 32'h44;
        tick();
        ld_wb_valid = 0; ld_issue_valid = 1; ld_issue_addr = 5'd2;
        #1;
        n_tests++;
        if (ld_issue_ready !== 1'b0 || pending_count !== 6'd3) begin
            n_fail++; $display("FAIL issue_waw: got rdy=%0b cnt=%0d want 0/3", ld_issue_ready, pending_count);
        end
        ld_issue_addr = 5'd9; ld_wb_valid = 1; ld_wb_addr = 5'd3; ld_wb_data = 32'h33;
        #1;
        n_tests++;
        if (ld_issue_ready !== 1'b1 || ld_wb_ready !== 1'b1) begin
            n_fail++; $display("FAIL same_edge_ready: got iss=%0b ld=%0b want 1/1", ld_issue_ready, ld_wb_ready);
        end
        tick();
        idle_inputs();
        tick();
        rd_addr_0 = 5'd9; rd_addr_1 = 5'd3;
        #1;
        n_tests++;
        if (pending_count !== 6'd3 || rd_hazard !== 1'b1 || sb_error !== 1'b0) begin
            n_fail++; $display("FAIL same_edge_count: got cnt=%0d haz=%0b err=%0b want 3/1/0", pending_count, rd_hazard, sb_error);
        end
        rd_addr_0 = 5'd3; rd_addr_1 = 5'd3;
        #1;
        n_tests++;
        if (rd_hazard !== 1'b0) begin
            n_fail++; $display("FAIL retired_r3_hazard: got %0b want 0", rd_hazard);
        end
    endtask

    task automatic test_error_and_reset();
        do_reset();
        ld_issue_valid = 1; ld_issue_addr = 5'd3;
        tick();
        ld_issue_valid = 0; alu_wb_valid = 1; alu_wb_addr = 5'd3; alu_wb_data = 32'hA5A5_0003;
        #1;
        n_tests++;
        if (sb_error !== 1'b0) begin
            n_fail++; $display("FAIL err_before: got %0b want 0", sb_error);
        end
        tick();
        alu_wb_valid = 0;
        #1;
        n_tests++;
        if (sb_error !== 1'b1 || rf_wr_enable !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 32'hA5A5_0003) begin
            n_fail++; $display("FAIL alu_to_pending: got err=%0b we=%0b wa=%0d wd=%h want 1/1/3/a5a50003",
                               sb_error, rf_wr_enable, rf_wr_addr, rf_wr_data);
        end
        ld_issue_valid = 1; ld_issue_addr = 5'd10; ld_wb_valid = 1; ld_wb_addr = 5'd10; ld_wb_data = 32'hA;
        tick();
        idle_inputs();
        tick();
        rd_addr_0 = 5'd10;
        #1;
        n_tests++;
        if (pending_count !== 6'd2 || rd_hazard !== 1'b1 || sb_error !== 1'b1) begin
            n_fail++; $display("FAIL same_reg_issue_wb: got cnt=%0d haz=%0b err=%0b want 2/1/1", pending_count, rd_hazard, sb_error);
        end
        alu_wb_valid = 1; alu_wb_addr = 5'd6; alu_wb_data = 32'h6;
        ld_issue_valid = 1; ld_issue_addr = 5'd11; rf_reset = 1;
        tick();
        rf_reset = 0; idle_inputs();
        #1;
        n_tests++;
        if (sb_error !== 1'b0 || pending_count !== 6'd0 || rf_wr_enable !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got err=%0b cnt=%0d we=%0b want 0/0/0", sb_error, pending_count, rf_wr_enable);
        end
    endtask

    task automatic test_random();
        bit a_acc, l_acc;
        int k;
        do_reset();
        a_acc = 0; l_acc = 0;
        for (int c = 0; c < 400; c++) begin
            if (!alu_wb_valid || a_acc) begin
                alu_wb_valid = ($urandom_range(0, 3) != 0);
                alu_wb_addr  = 5'($urandom_range(0, 31));
                alu_wb_data  = $urandom;
            end
            if (!ld_wb_valid || l_acc) begin
                ld_wb_valid = ($urandom_range(0, 2) == 0);
                k = $urandom_range(0, 31);
                if (m_pend != 0 && $urandom_range(0, 3) != 0)
                    while (!m_pend[k]) k = (k + 1) % 32;
                ld_wb_addr = 5'(k);
                ld_wb_data = $urandom;
            end
            ld_issue_valid = $urandom_range(0, 1) == 1;
            ld_issue_addr  = 5'($urandom_range(0, 31));
            rd_addr_0      = 5'($urandom_range(0, 31));
            rd_addr_1      = ($urandom_range(0, 1) == 1) ? ld_issue_addr : 5'($urandom_range(0, 31));
            rf_reset       = ($urandom_range(0, 99) == 0);
            #1;
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            a_acc = rf_reset || (alu_wb_valid && !m_ld_grant());
            l_acc = rf_reset || (ld_wb_valid && m_ld_grant());
            tick();
        end
        rf_reset = 0;
        idle_inputs();
    endtask

    initial begin
        rf_reset = 1;
        idle_inputs();
        @(negedge rf_clock);
        test_reset();
        test_alu_write();
        test_load_hazard();
        test_starve();
        test_max_pending();
        test_error_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
